// File: rtl/led_pkg.sv
// Shared constants for the GPIO LED bank controllers: step modes and
// running-light direction encodings.
package led_pkg;

    localparam logic [1:0] MODE_WRAP   = 2'd0;
    localparam logic [1:0] MODE_BOUNCE = 2'd1;
    localparam logic [1:0] MODE_PAUSE  = 2'd2;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

endpackage : led_pkg

// File: rtl/tick_gen.sv
// Step-rate divider: emits a registered single-cycle strobe once every
// TICK_DIV enabled clock cycles.
module tick_gen #(
    parameter int TICK_DIV = 600_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(TICK_DIV - 2);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    // The strobe is registered, so it is raised on the edge that moves the
    // count onto its last value; it then coincides with count == TICK_DIV-1.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (i_en) begin
            cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
            tick_d = (cnt_q == CNT_PRE);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign o_tick = tick_q;

endmodule : tick_gen

// File: rtl/running_light_ctrl.sv
// Running-light controller: one lit LED stepping across N_LED outputs in
// wrap, bounce or pause mode, with a windowed direction-toggle button.
module running_light_ctrl
    import led_pkg::*;
#(
    parameter int N_LED    = 8,
    parameter int TICK_DIV = 600_000_000,
    parameter int WIN_LO   = 2,
    parameter int WIN_HI   = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_btn,
    input  logic                     i_en,
    input  logic [1:0]               i_mode,
    output logic [N_LED-1:0]         o_led,
    output logic [$clog2(N_LED)-1:0] o_pos,
    output logic                     o_dir,
    output logic                     o_tick
);

    localparam int PW = $clog2(N_LED);
    localparam logic [PW-1:0]    POS_MAX = PW'(N_LED - 1);
    localparam logic [PW-1:0]    WIN_LO_P = PW'(WIN_LO);
    localparam logic [PW-1:0]    WIN_HI_P = PW'(WIN_HI);
    localparam logic [N_LED-1:0] LED_RST = {1'b1, {(N_LED-1){1'b0}}};

    logic             tick;
    logic [PW-1:0]    pos_q, pos_d;
    logic             dir_q, dir_d;
    logic [N_LED-1:0] led_q, led_d;
    logic             in_win;
    logic             dir_t;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .i_en   (i_en),
        .o_tick (tick)
    );

    // The window is judged on the pre-step position; a same-cycle step
    // then moves in the already toggled direction.
    assign in_win = (pos_q >= WIN_LO_P) && (pos_q <= WIN_HI_P);
    assign dir_t  = dir_q ^ (i_btn & in_win);

    always_comb begin
        pos_d = pos_q;
        dir_d = dir_t;
        if (tick) begin
            case (i_mode)
                MODE_WRAP: begin
                    if (dir_t == DIR_RIGHT) pos_d = (pos_q == '0) ? POS_MAX : pos_q - PW'(1);
                    else                    pos_d = (pos_q == POS_MAX) ? '0 : pos_q + PW'(1);
                end
                MODE_BOUNCE: begin
                    // End reversal wins over any toggle: direction always points inward.
                    if (dir_t == DIR_RIGHT && pos_q == '0) begin
                        dir_d = DIR_LEFT;
                        pos_d = PW'(1);
                    end else if (dir_t == DIR_LEFT && pos_q == POS_MAX) begin
                        dir_d = DIR_RIGHT;
                        pos_d = POS_MAX - PW'(1);
                    end else if (dir_t == DIR_RIGHT) begin
                        pos_d = pos_q - PW'(1);
                    end else begin
                        pos_d = pos_q + PW'(1);
                    end
                end
                MODE_PAUSE: pos_d = pos_q;
                default:    pos_d = pos_q;
            endcase
        end
        led_d = N_LED'(1) << pos_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pos_q <= POS_MAX;
            dir_q <= DIR_RIGHT;
            led_q <= LED_RST;
        end else begin
            pos_q <= pos_d;
            dir_q <= dir_d;
            led_q <= led_d;
        end
    end

    assign o_led  = led_q;
    assign o_pos  = pos_q;
    assign o_dir  = dir_q;
    assign o_tick = tick;

endmodule : running_light_ctrl

// File: tb/tb_running_light_ctrl.sv
// Directed bench for running_light_ctrl with N_LED=8, TICK_DIV=4: a table
// of per-step vectors plus hand-written enable-hold and reset sequences.
module tb_running_light_ctrl;
    import led_pkg::*;

    localparam int N_LED    = 8;
    localparam int TICK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_btn;
    logic       i_en;
    logic [1:0] i_mode;
    logic [7:0] o_led;
    logic [2:0] o_pos;
    logic       o_dir;
    logic       o_tick;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int last_tick = -1;

    typedef struct {
        logic [1:0] mode;
        logic       btn_mid;
        logic       exp_dir_mid;
        logic       btn_tick;
        logic [7:0] exp_led;
        logic       exp_dir;
    } vec_t;

    vec_t vecs[$];

    running_light_ctrl #(
        .N_LED    (N_LED),
        .TICK_DIV (TICK_DIV),
        .WIN_LO   (2),
        .WIN_HI   (3)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .i_btn  (i_btn),
        .i_en   (i_en),
        .i_mode (i_mode),
        .o_led  (o_led),
        .o_pos  (o_pos),
        .o_dir  (o_dir),
        .o_tick (o_tick)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int idx_of(input logic [7:0] l);
        int r = -1;
        for (int b = 0; b < 8; b++) if (l[b]) r = b;
        return r;
    endfunction

    function automatic vec_t mk(input logic [1:0] m, input logic bm, input logic dm,
                                input logic bt, input logic [7:0] led, input logic dir);
        vec_t v;
        v.mode = m; v.btn_mid = bm; v.exp_dir_mid = dm;
        v.btn_tick = bt; v.exp_led = led; v.exp_dir = dir;
        return v;
    endfunction

    // Advance until o_tick is seen (bounded); checks the tick period when a
    // previous tick is known. Returns with the tick cycle being observed.
    task automatic wait_tick(output bit ok, output int tcyc);
        ok = 1'b0;
        tcyc = -1;
        for (int k = 0; k < 10 && !ok; k++) begin
            @(posedge clk); #1;
            if (o_tick) begin
                ok = 1'b1;
                tcyc = cyc;
            end
        end
        if (!ok) begin
            check("tick_timeout", 64'd0, 64'd1);
        end else begin
            if (last_tick >= 0) check("tick_period", 64'(tcyc - last_tick), 64'(TICK_DIV));
            last_tick = tcyc;
        end
    endtask

    initial begin
        bit ok;
        int tc;
        int ref_cyc;
        bit tick_seen;
        bit led_moved;

        // Rows 1-12: plain WRAP from reset.
        for (int s = 0; s < 12; s++) begin
            logic [7:0] l;
            l = 8'h80 >> ((s + 1) % 8);
            vecs.push_back(mk(MODE_WRAP, 0, 0, 0, l, 0));
        end
        vecs.push_back(mk(MODE_WRAP,   1, 1, 0, 8'h10, 1)); // toggle inside window at pos 3
        vecs.push_back(mk(MODE_WRAP,   0, 0, 0, 8'h20, 1));
        vecs.push_back(mk(MODE_WRAP,   1, 1, 0, 8'h40, 1)); // pulse at pos 5 ignored
        vecs.push_back(mk(MODE_WRAP,   0, 0, 0, 8'h80, 1));
        vecs.push_back(mk(MODE_WRAP,   0, 0, 0, 8'h01, 1)); // wrap upward
        vecs.push_back(mk(MODE_WRAP,   0, 0, 0, 8'h02, 1));
        vecs.push_back(mk(MODE_WRAP,   0, 0, 0, 8'h04, 1));
        vecs.push_back(mk(MODE_WRAP,   0, 0, 1, 8'h02, 0)); // btn with tick, pos 2 dir 1
        vecs.push_back(mk(MODE_WRAP,   0, 0, 1, 8'h01, 0)); // btn with tick, pos 1 ignored
        vecs.push_back(mk(MODE_BOUNCE, 0, 0, 0, 8'h02, 1)); // bounce at LSB
        vecs.push_back(mk(MODE_BOUNCE, 0, 0, 0, 8'h04, 1));
        vecs.push_back(mk(MODE_BOUNCE, 0, 0, 1, 8'h02, 0));
        vecs.push_back(mk(MODE_BOUNCE, 0, 0, 0, 8'h01, 0));
        vecs.push_back(mk(MODE_BOUNCE, 0, 0, 0, 8'h02, 1));
        vecs.push_back(mk(MODE_BOUNCE, 0, 0, 0, 8'h04, 1));
        vecs.push_back(mk(MODE_BOUNCE, 1, 0, 1, 8'h08, 1)); // pos 2 dir 0 + btn with tick
        vecs.push_back(mk(MODE_BOUNCE, 0, 0, 0, 8'h10, 1));
        vecs.push_back(mk(MODE_BOUNCE, 0, 0, 0, 8'h20, 1));
        vecs.push_back(mk(MODE_BOUNCE, 0, 0, 0, 8'h40, 1));
        vecs.push_back(mk(MODE_BOUNCE, 0, 0, 0, 8'h80, 1));
        vecs.push_back(mk(MODE_BOUNCE, 0, 0, 0, 8'h40, 0)); // bounce at MSB
        vecs.push_back(mk(MODE_BOUNCE, 0, 0, 0, 8'h20, 0));
        vecs.push_back(mk(MODE_PAUSE,  0, 0, 0, 8'h20, 0));
        vecs.push_back(mk(MODE_PAUSE,  0, 0, 0, 8'h20, 0));
        vecs.push_back(mk(MODE_PAUSE,  0, 0, 0, 8'h20, 0));
        vecs.push_back(mk(2'd3,        0, 0, 0, 8'h20, 0)); // reserved behaves as pause
        vecs.push_back(mk(MODE_WRAP,   0, 0, 0, 8'h10, 0));
        vecs.push_back(mk(MODE_WRAP,   0, 0, 0, 8'h08, 0));
        vecs.push_back(mk(MODE_PAUSE,  1, 1, 0, 8'h08, 1)); // toggle accepted while paused
        vecs.push_back(mk(MODE_WRAP,   0, 0, 0, 8'h10, 1));

        rst = 1'b1; i_btn = 1'b0; i_en = 1'b1; i_mode = MODE_WRAP;
        repeat (2) @(posedge clk);
        #1;
        check("reset_led",  64'(o_led),  64'h80);
        check("reset_pos",  64'(o_pos),  64'd7);
        check("reset_dir",  64'(o_dir),  64'd0);
        check("reset_tick", 64'(o_tick), 64'd0);
        rst = 1'b0;
        ref_cyc = cyc;

        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            i_mode = v.mode;
            if (v.btn_mid) begin
                i_btn = 1'b1;
                @(posedge clk); #1;
                i_btn = 1'b0;
                check($sformatf("row%0d_dir_mid", i), 64'(o_dir), 64'(v.exp_dir_mid));
            end
            wait_tick(ok, tc);
            if (ok) begin
                if (i == 0) check("first_tick_cycle", 64'(tc - ref_cyc), 64'(TICK_DIV - 1));
                i_btn = v.btn_tick;
                @(posedge clk); #1;
                i_btn = 1'b0;
                check($sformatf("row%0d_led", i),  64'(o_led),  64'(v.exp_led));
                check($sformatf("row%0d_pos", i),  64'(o_pos),  64'(idx_of(v.exp_led)));
                check($sformatf("row%0d_dir", i),  64'(o_dir),  64'(v.exp_dir));
                check($sformatf("row%0d_tick", i), 64'(o_tick), 64'd0);
            end
        end

        // Enable held low: no tick, no movement; counter resumes from its held value.
        i_en = 1'b0;
        tick_seen = 1'b0;
        led_moved = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            tick_seen |= o_tick;
            led_moved |= (o_led !== 8'h10);
        end
        check("hold_no_tick", 64'(tick_seen), 64'd0);
        check("hold_led",     64'(led_moved), 64'd0);
        i_en = 1'b1;
        ref_cyc = cyc;
        last_tick = -1;
        wait_tick(ok, tc);
        if (ok) begin
            check("resume_tick_cycle", 64'(tc - ref_cyc), 64'(TICK_DIV - 1));
            @(posedge clk); #1;
            check("resume_step_led", 64'(o_led), 64'h20);
        end

        // Reset in a tick cycle with a button pulse and a mode change present.
        wait_tick(ok, tc);
        rst = 1'b1; i_btn = 1'b1; i_mode = MODE_BOUNCE;
        @(posedge clk); #1;
        check("midrst_led",  64'(o_led),  64'h80);
        check("midrst_pos",  64'(o_pos),  64'd7);
        check("midrst_dir",  64'(o_dir),  64'd0);
        check("midrst_tick", 64'(o_tick), 64'd0);
        rst = 1'b0; i_btn = 1'b0; i_mode = MODE_WRAP;
        ref_cyc = cyc;
        last_tick = -1;
        wait_tick(ok, tc);
        if (ok) begin
            check("midrst_first_tick", 64'(tc - ref_cyc), 64'(TICK_DIV - 1));
            @(posedge clk); #1;
            check("midrst_step_led", 64'(o_led), 64'h40);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_running_light_ctrl
